desc_row_reader: RTL and testbench

Parametrised successor of the credit-return packet reader. It accepts packet indices on N_CH AXI-stream inputs and arbitrates between them round-robin. For each index it fetches a descriptor {size, row} from RAM A, then streams `size` words from consecutive rows of RAM B onto one AXI-stream output with tlast and channel id. RAM B reads are credit-gated by free space in an internal output FIFO, so backpressure never drops data.

---
 rtl/desc_row_reader_pkg.sv | 39 +++
 rtl/desc_row_reader_if.sv | 54 +++++
 rtl/desc_row_reader_fifo.sv | 53 +++++
 rtl/desc_row_reader.sv | 177 +++++++++++++++++
 tb/tb_desc_row_reader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/desc_row_reader_pkg.sv
// Shared types and default widths for the descriptor row reader.
// Structs below are sized for the default configuration.
package desc_row_pkg;

  localparam int N_CH_D   = 2;
  localparam int IDX_W_D  = 8;
  localparam int ROW_W_D  = 8;
  localparam int SIZE_W_D = 8;
  localparam int WORD_W_D = 16;
  localparam int WPR_D    = 16;
  localparam int DEPTH_D  = 32;

  function automatic int uw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int USER_W_D = uw(N_CH_D);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WAIT_A,
    REQ_B,
    WAIT_B,
    UNLOAD
  } state_t;

  typedef struct packed {
    logic [SIZE_W_D-1:0] size;
    logic [ROW_W_D-1:0]  row;
  } desc_t;

  typedef struct packed {
    logic [USER_W_D-1:0] user;
    logic                last;
    logic [WORD_W_D-1:0] data;
  } fifo_ent_t;

endpackage

// File: rtl/desc_row_reader_if.sv
// Bundle of index inputs, packet output and both RAM read ports.
// master is the reader, slave is the surrounding system.
interface desc_row_reader_if
  import desc_row_pkg::*;
#(
  parameter int N_CH          = N_CH_D,
  parameter int IDX_W         = IDX_W_D,
  parameter int ROW_W         = ROW_W_D,
  parameter int SIZE_W        = SIZE_W_D,
  parameter int WORD_W        = WORD_W_D,
  parameter int WORDS_PER_ROW = WPR_D
);
  localparam int UW = uw(N_CH);

  logic [N_CH*IDX_W-1:0]           in_tdata;
  logic [N_CH-1:0]                 in_tvalid;
  logic [N_CH-1:0]                 in_tready;
  logic [WORD_W-1:0]               out_tdata;
  logic                            out_tvalid;
  logic                            out_tready;
  logic                            out_tlast;
  logic [UW-1:0]                   out_tuser;
  logic [IDX_W-1:0]                rd_a_addr;
  logic                            rd_a_read;
  logic [SIZE_W+ROW_W-1:0]         rd_a_data;
  logic                            rd_a_valid;
  logic [ROW_W-1:0]                rd_b_addr;
  logic                            rd_b_read;
  logic [WORD_W*WORDS_PER_ROW-1:0] rd_b_data;
  logic                            rd_b_valid;

  modport master (
    input  in_tdata, in_tvalid,
    output in_tready,
    output out_tdata, out_tvalid, out_tlast, out_tuser,
    input  out_tready,
    output rd_a_addr, rd_a_read,
    input  rd_a_data, rd_a_valid,
    output rd_b_addr, rd_b_read,
    input  rd_b_data, rd_b_valid
  );

  modport slave (
    output in_tdata, in_tvalid,
    input  in_tready,
    input  out_tdata, out_tvalid, out_tlast, out_tuser,
    output out_tready,
    input  rd_a_addr, rd_a_read,
    output rd_a_data, rd_a_valid,
    input  rd_b_addr, rd_b_read,
    output rd_b_data, rd_b_valid
  );

endinterface

// File: rtl/desc_row_reader_fifo.sv
// Synchronous FIFO with occupancy count, used for output credits.
// A push into a full FIFO is legal only together with a pop.
module sync_fifo #(
  parameter int  W     = 8,
  parameter int  DEPTH = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          pop_ok, full;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_ok = pop & ~empty;
  assign dout   = mem[rp];

  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)
        wp <= wp + AW'(1);
      if (pop_ok)
        rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(push && full && !pop_ok))
        else $error("sync_fifo: push while full");
  end

endmodule

// File: rtl/desc_row_reader.sv
// Round-robin index reader: descriptor fetch from RAM A, row stream from RAM B.
// Row reads are credit-gated against output FIFO space.
module desc_row_reader
  import desc_row_pkg::*;
#(
  parameter int N_CH          = N_CH_D,
  parameter int IDX_W         = IDX_W_D,
  parameter int ROW_W         = ROW_W_D,
  parameter int SIZE_W        = SIZE_W_D,
  parameter int WORD_W        = WORD_W_D,
  parameter int WORDS_PER_ROW = WPR_D,
  parameter int FIFO_DEPTH    = DEPTH_D
) (
  input logic                aclk,
  input logic                areset,
  desc_row_reader_if.master  bus
);

  localparam int UW = uw(N_CH);
  localparam int NW = $clog2(WORDS_PER_ROW) + 1;
  localparam int WI = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic [ROW_W-1:0]  row;
  } desc_p_t;

  typedef struct packed {
    logic [UW-1:0]     user;
    logic              last;
    logic [WORD_W-1:0] data;
  } ent_p_t;

  state_t                          state;
  logic [UW-1:0]                   grant, rr_ptr, pick;
  logic                            any_req;
  logic [N_CH-1:0]                 in_rdy;
  logic                            a_rd, b_rd;
  logic [IDX_W-1:0]                a_addr;
  logic [ROW_W-1:0]                b_addr, row;
  logic [SIZE_W-1:0]               rem;
  logic [NW-1:0]                   n_c, n_q;
  logic [WI-1:0]                   w;
  logic [WORD_W*WORDS_PER_ROW-1:0] row_q;
  logic [CW-1:0]                   resv, cnt, free_c;
  logic                            push, pop, empty;
  logic                            credit_ok, row_done;
  desc_p_t                         dsc;
  ent_p_t                          ent_i, ent_o;

  // first requester at or after rr_ptr; descending scan keeps the nearest
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.in_tvalid[(int'(rr_ptr) + i) % N_CH]) begin
        any_req = 1'b1;
        pick    = UW'((int'(rr_ptr) + i) % N_CH);
      end
    end
  end

  always_comb begin
    n_c = (int'(rem) >= WORDS_PER_ROW) ? NW'(WORDS_PER_ROW) : NW'(rem);
  end

  assign dsc       = desc_p_t'(bus.rd_a_data);
  assign free_c    = CW'(FIFO_DEPTH) - cnt - resv;
  assign credit_ok = (free_c >= CW'(n_c));
  assign row_done  = ((NW'(w) + NW'(1)) == n_q);
  assign push      = (state == UNLOAD);

  assign ent_i.user = grant;
  assign ent_i.last = (rem == SIZE_W'(1));
  assign ent_i.data = row_q[int'(w)*WORD_W +: WORD_W];

  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      in_rdy <= '0;
      a_rd   <= 1'b0;
      a_addr <= '0;
      b_rd   <= 1'b0;
      b_addr <= '0;
      row    <= '0;
      rem    <= '0;
      n_q    <= '0;
      w      <= '0;
      row_q  <= '0;
      resv   <= '0;
    end else begin
      in_rdy <= '0;
      a_rd   <= 1'b0;
      b_rd   <= 1'b0;
      if (push)
        resv <= resv - CW'(1);
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= pick;
            in_rdy <= N_CH'(1) << pick;
            a_rd   <= 1'b1;
            a_addr <= bus.in_tdata[int'(pick)*IDX_W +: IDX_W];
            state  <= ACCEPT;
          end
        end
        ACCEPT: begin
          rr_ptr <= (int'(grant) == N_CH - 1) ? '0 : grant + UW'(1);
          state  <= WAIT_A;
        end
        WAIT_A: begin
          if (bus.rd_a_valid) begin
            rem   <= dsc.size;
            row   <= dsc.row;
            w     <= '0;
            state <= (dsc.size == '0) ? IDLE : REQ_B;
          end
        end
        REQ_B: begin
          if (credit_ok) begin
            b_rd   <= 1'b1;
            b_addr <= row;
            n_q    <= n_c;
            resv   <= resv + CW'(n_c);
            state  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.rd_b_valid) begin
            row_q <= bus.rd_b_data;
            w     <= '0;
            state <= UNLOAD;
          end
        end
        UNLOAD: begin
          rem <= rem - SIZE_W'(1);
          w   <= w + WI'(1);
          if (row_done) begin
            w     <= '0;
            row   <= row + ROW_W'(1);
            state <= (rem == SIZE_W'(1)) ? IDLE : REQ_B;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .W     ($bits(ent_p_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (push),
    .din   (ent_i),
    .pop   (pop),
    .dout  (ent_o),
    .empty (empty),
    .count (cnt)
  );

  assign pop            = ~empty & bus.out_tready;
  assign bus.out_tvalid = ~empty;
  assign bus.out_tdata  = empty ? '0 : ent_o.data;
  assign bus.out_tlast  = empty ? 1'b0 : ent_o.last;
  assign bus.out_tuser  = empty ? '0 : ent_o.user;
  assign bus.in_tready  = in_rdy;
  assign bus.rd_a_read  = a_rd;
  assign bus.rd_a_addr  = a_addr;
  assign bus.rd_b_read  = b_rd;
  assign bus.rd_b_addr  = b_addr;

endmodule

// File: tb/tb_desc_row_reader.sv
// Directed bench for desc_row_reader with behavioural RAM A/B models.
// RAM A answers 2 cycles after a read, RAM B 3 cycles after.
module tb_desc_row_reader;
  import desc_row_pkg::*;

  logic aclk;
  logic areset;
  logic stray_b;

  int checks = 0;
  int errors = 0;
  int b_pulses = 0;

  logic [31:0] q[$];
  desc_t       ram_a [256];

  logic [1:0] a_v = '0;
  logic [7:0] a_ad0 = '0;
  logic [7:0] a_ad1 = '0;
  logic [2:0] b_v = '0;
  logic [7:0] b_ad0 = '0;
  logic [7:0] b_ad1 = '0;
  logic [7:0] b_ad2 = '0;

  int au [6] = '{0, 1, 1, 0, 1, 1};
  int al [6] = '{1, 0, 1, 1, 0, 1};
  int ad [6] = '{'h0A00, 'h0A20, 'h0A21, 'h0A00, 'h0A20, 'h0A21};

  desc_row_reader_if bus ();

  desc_row_reader dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) begin
    a_v   <= {a_v[0], bus.rd_a_read};
    a_ad0 <= bus.rd_a_addr;
    a_ad1 <= a_ad0;
    b_v   <= {b_v[1:0], bus.rd_b_read};
    b_ad0 <= bus.rd_b_addr;
    b_ad1 <= b_ad0;
    b_ad2 <= b_ad1;
  end

  assign bus.rd_a_valid = a_v[1];
  assign bus.rd_a_data  = ram_a[a_ad1];
  assign bus.rd_b_valid = b_v[2] | stray_b;

  always_comb begin
    bus.rd_b_data = '0;
    for (int k = 0; k < 16; k++)
      bus.rd_b_data[k*16 +: 16] = 16'h0A00 + 16'({b_ad2, 4'h0}) + 16'(k);
  end

  always @(negedge aclk) begin
    if (bus.out_tvalid && bus.out_tready)
      q.push_back({14'd0, bus.out_tuser, bus.out_tlast, bus.out_tdata});
    if (bus.rd_b_read)
      b_pulses++;
  end

  function automatic logic [31:0] ent(int u, bit l, int d);
    return {14'd0, u[0], l, d[15:0]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic send(int ch, logic [7:0] idx);
    bit done;
    done = 1'b0;
    bus.in_tdata[ch*8 +: 8] = idx;
    bus.in_tvalid[ch] = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge aclk);
      if (bus.in_tready[ch]) begin
        @(posedge aclk);
        #1;
        done = 1'b1;
      end
    end
    bus.in_tvalid[ch] = 1'b0;
    check($sformatf("handshake_%0h", idx), 32'(done), 1);
  endtask

  task automatic wait_words(string tag, int n);
    int i;
    i = 0;
    while (q.size() < n && i < 2000) begin
      @(negedge aclk);
      i++;
    end
    check({tag, "_wait"}, 32'(q.size() >= n), 1);
  endtask

  task automatic expect_pkt(string tag, int u, int r0, int size);
    logic [31:0] got;
    wait_words(tag, size);
    for (int k = 0; k < size; k++) begin
      got = (q.size() > 0) ? q.pop_front() : 32'hDEAD0000;
      check($sformatf("%s[%0d]", tag, k), got,
            ent(u, k == size - 1, 'h0A00 + ((16 * r0 + k) % 4096)));
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_in_tready"}, 32'(bus.in_tready), 0);
    check({tag, "_out_tvalid"}, 32'(bus.out_tvalid), 0);
    check({tag, "_out_tlast"}, 32'(bus.out_tlast), 0);
    check({tag, "_out_tdata"}, 32'(bus.out_tdata), 0);
    check({tag, "_out_tuser"}, 32'(bus.out_tuser), 0);
    check({tag, "_rd_a_read"}, 32'(bus.rd_a_read), 0);
    check({tag, "_rd_b_read"}, 32'(bus.rd_b_read), 0);
    check({tag, "_rd_a_addr"}, 32'(bus.rd_a_addr), 0);
    check({tag, "_rd_b_addr"}, 32'(bus.rd_b_addr), 0);
  endtask

  initial begin
    int  base;
    bit  found;

    for (int i = 0; i < 256; i++)
      ram_a[i] = '0;
    for (int i = 0; i < 16; i++)
      ram_a[i] = '{size: 8'(i + 1), row: 8'(2 * i)};
    ram_a[8'h20] = '{size: 8'd20, row: 8'd5};
    ram_a[8'h21] = '{size: 8'd18, row: 8'hFF};
    ram_a[8'h30] = '{size: 8'd0, row: 8'd0};

    areset         = 1'b1;
    stray_b        = 1'b0;
    bus.in_tdata   = '0;
    bus.in_tvalid  = '0;
    bus.out_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_vals("rst");
    @(negedge aclk);
    areset = 1'b0;

    // single packet from channel 0
    send(0, 8'h0F);
    expect_pkt("single", 0, 30, 16);

    // packet spanning two rows
    base = b_pulses;
    send(0, 8'h20);
    expect_pkt("span", 0, 5, 20);
    check("span_reads", 32'(b_pulses - base), 2);

    // row address wraps from 0xFF to 0x00
    send(0, 8'h21);
    expect_pkt("wrap", 0, 255, 18);

    // zero-size descriptor emits nothing
    send(0, 8'h30);
    send(0, 8'h00);
    expect_pkt("zero", 0, 0, 1);
    repeat (20) @(negedge aclk);
    check("zero_extra", 32'(q.size()), 0);

    // credit gating under full backpressure
    bus.out_tready = 1'b0;
    base = b_pulses;
    send(0, 8'h0F);
    send(0, 8'h0F);
    send(0, 8'h0F);
    repeat (30) @(negedge aclk);
    check("credit_reads_held", 32'(b_pulses - base), 2);
    check("credit_fifo_count", 32'(dut.cnt), 32);
    check("credit_head", {14'd0, bus.out_tuser, bus.out_tlast, bus.out_tdata},
          ent(0, 0, 'h0BE0));
    repeat (5) @(negedge aclk);
    check("credit_head_stable",
          {14'd0, bus.out_tuser, bus.out_tlast, bus.out_tdata}, ent(0, 0, 'h0BE0));
    check("credit_valid", 32'(bus.out_tvalid), 1);
    bus.out_tready = 1'b1;
    expect_pkt("credit_p0", 0, 30, 16);
    expect_pkt("credit_p1", 0, 30, 16);
    expect_pkt("credit_p2", 0, 30, 16);
    check("credit_reads_all", 32'(b_pulses - base), 3);

    // fresh round-robin pointer, then both channels request continuously
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    q.delete();
    bus.in_tdata  = 16'h0100;
    bus.in_tvalid = 2'b11;
    wait_words("arb", 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("arb[%0d]", k), (q.size() > 0) ? q.pop_front() : 32'hDEAD0000,
            ent(au[k], al[k] != 0, ad[k]));

    // reset in the middle of a row unload
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge aclk);
      if (dut.state == UNLOAD)
        found = 1'b1;
    end
    check("unload_seen", 32'(found), 1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check_reset_vals("midrst");
    bus.in_tvalid = '0;
    q.delete();
    @(negedge aclk);
    areset  = 1'b0;
    stray_b = 1'b1;
    @(negedge aclk);
    stray_b = 1'b0;
    repeat (10) @(negedge aclk);
    check("stray_out_tvalid", 32'(bus.out_tvalid), 0);
    check("stray_words", 32'(q.size()), 0);
    check("stray_rd_b_read", 32'(bus.rd_b_read), 0);

    bus.in_tvalid = 2'b11;
    wait_words("post", 3);
    bus.in_tvalid = '0;
    for (int k = 0; k < 3; k++)
      check($sformatf("post[%0d]", k), (q.size() > 0) ? q.pop_front() : 32'hDEAD0000,
            ent(au[k], al[k] != 0, ad[k]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
